// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 fetch stage.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ,
        DROP,
        HOLD
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that keeps a fetched word (and its PC) while
// decode is stalled.
module fetch_hold_buf
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [31:0]        pc_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [31:0]        pc_q
);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
        end else if (clear) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory
// and drives the IF/ID register consumed by decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4
);

    fetch_state_t       state;
    logic [31:0]        pc;
    logic [31:0]        target;
    logic               ack;
    logic               can_load;
    logic               load_if;
    logic               buf_load;
    logic               buf_clear;
    logic [INSTR_W-1:0] load_instr;
    logic [31:0]        load_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic [31:0]        buf_pc;
    logic [31:0]        redirect_aligned;
    logic [31:0]        pc_next_seq;

    // The request is held through DROP so the address stays stable until ack.
    assign imem_req         = !reset && (state != HOLD);
    assign imem_addr        = pc;
    assign ack              = imem_ack && imem_req;
    assign can_load         = !if_valid || !stall;
    assign redirect_aligned = word_align(redirect_pc);
    assign pc_next_seq      = pc + 32'd4;

    // NOTE: defaults first so every path assigns every output and no latch forms.
    always_comb begin
        load_if    = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        load_instr = imem_rdata;
        load_pc    = pc;
        if (redirect) begin
            buf_clear = (state == HOLD);
        end else begin
            case (state)
                REQ: begin
                    if (ack) begin
                        load_if  = can_load;
                        buf_load = !can_load;
                    end
                end
                HOLD: begin
                    if (can_load) begin
                        load_if    = 1'b1;
                        load_instr = buf_instr;
                        load_pc    = buf_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (buf_load),
        .clear   (buf_clear),
        .instr_d (imem_rdata),
        .pc_d    (pc),
        .instr_q (buf_instr),
        .pc_q    (buf_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= REQ;
            pc          <= RESET_PC;
            target      <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= 32'h0;
            if_pc_plus4 <= 32'h0;
        end else begin
            case (state)
                REQ: begin
                    if (ack) begin
                        if (redirect) begin
                            pc <= redirect_aligned;
                        end else begin
                            pc <= pc_next_seq;
                            if (!can_load) state <= HOLD;
                        end
                    end else if (redirect) begin
                        target <= redirect_aligned;
                        state  <= DROP;
                    end
                end
                DROP: begin
                    if (redirect) target <= redirect_aligned;
                    if (ack) begin
                        pc    <= redirect ? redirect_aligned : target;
                        state <= REQ;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_aligned;
                        state <= REQ;
                    end else if (can_load) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase

            // A redirect squashes IF/ID even while decode is stalled.
            if (redirect) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end else if (load_if) begin
                if_valid    <= 1'b1;
                if_instr    <= load_instr;
                if_pc       <= load_pc;
                if_pc_plus4 <= load_pc + 32'd4;
            end else if (!stall) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by randomized
// stall/redirect/latency traffic against a program-order reference model.
module tb_fetch_unit;

    localparam logic [31:0] TAG = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        rst_w;
    logic        req_w;
    logic [31:0] addr_w;
    logic        valid_w;
    logic [31:0] instr_w;
    logic [31:0] pc_w;
    logic [31:0] p4_w;

    int n_checks = 0;
    int n_err    = 0;
    int n_consumed = 0;

    int lat_min = 0;
    int lat_max = 0;
    int lat_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] next_pc;

    always #5 clk = ~clk;

    // Memory: every word holds addr ^ TAG; ack after lat_cnt wait cycles.
    assign imem_ack   = imem_req && (lat_cnt == 0);
    assign imem_rdata = imem_addr ^ TAG;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk         (clk),
        .reset       (rst_w),
        .imem_req    (req_w),
        .imem_addr   (addr_w),
        .imem_ack    (req_w),
        .imem_rdata  (addr_w ^ TAG),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .if_valid    (valid_w),
        .if_instr    (instr_w),
        .if_pc       (pc_w),
        .if_pc_plus4 (p4_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    // Program order restarts at a (word-aligned) new address.
    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        next_pc = start & ~32'h3;
        sb_refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_refill();
    endtask

    // Latency bookkeeping for the memory model.
    initial begin
        logic taken;
        logic waiting;
        forever begin
            @(negedge clk);
            taken   = imem_req && imem_ack;
            waiting = imem_req && !imem_ack;
            @(posedge clk);
            #1;
            if (reset)
                lat_cnt = $urandom_range(lat_max, lat_min);
            else if (taken)
                lat_cnt = $urandom_range(lat_max, lat_min);
            else if (waiting && lat_cnt > 0)
                lat_cnt = lat_cnt - 1;
        end
    end

    // Monitor: compares every instruction decode consumes against the scoreboard.
    initial begin
        logic        prev_wait;
        logic        prev_redir;
        logic [31:0] prev_addr;
        logic [31:0] e;
        prev_wait  = 1'b0;
        prev_redir = 1'b0;
        prev_addr  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wait  = 1'b0;
                prev_redir = 1'b0;
            end else begin
                if (prev_redir) check("flush_valid", {31'b0, if_valid}, 32'h0);
                if (prev_wait) begin
                    check("wait_req_held", {31'b0, imem_req}, 32'h1);
                    check("wait_addr_stable", imem_addr, prev_addr);
                end
                if (imem_req) check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
                if (!if_valid) check("nop_when_invalid", if_instr, 32'h0);
                if (if_valid && !stall && !redirect) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL sb_empty: got pc %h expected no instruction", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", if_pc, e);
                        check("sb_instr", if_instr, e ^ TAG);
                        check("sb_pc_plus4", if_pc_plus4, e + 32'd4);
                        n_consumed++;
                    end
                end
                prev_wait  = imem_req && !imem_ack;
                prev_addr  = imem_addr;
                prev_redir = redirect;
            end
        end
    end

    initial begin
        logic seen;
        int   rand_start;
        reset       = 1'b1;
        rst_w       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        sb_restart(32'h0);

        tick();
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_pc_plus4", if_pc_plus4, 32'h0);
        tick();

        // Back-to-back fetch with same-cycle ack.
        reset = 1'b0;
        sb_restart(32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stream_valid", {31'b0, if_valid}, 32'h1);
            check("stream_pc", if_pc, 32'(4 * k));
        end

        // Stall at pc 8: next word parks in the hold buffer, no requests.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", if_pc, 32'h8);
            check("stall_valid", {31'b0, if_valid}, 32'h1);
            check("stall_no_req", {31'b0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        tick();
        check("unhold_pc", if_pc, 32'hC);
        check("unhold_req", {31'b0, imem_req}, 32'h1);
        tick();
        check("after_hold_pc", if_pc, 32'h10);

        // Two-cycle ack latency with a redirect in the wait cycle.
        lat_min = 2;
        lat_max = 2;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb_restart(32'h0);
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        check("slow_first_pc", if_pc, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        sb_restart(32'h40);
        tick();
        redirect = 1'b0;
        check("drop_valid", {31'b0, if_valid}, 32'h0);
        check("drop_addr", imem_addr, 32'h4);
        seen = 1'b0;
        for (int i = 0; i < 12 && !if_valid; i++) begin
            tick();
            if (imem_req && imem_addr != 32'h4 && !seen) begin
                check("drop_next_addr", imem_addr, 32'h40);
                seen = 1'b1;
            end
        end
        check("drop_target_seen", {31'b0, seen}, 32'h1);
        check("drop_arrive_valid", {31'b0, if_valid}, 32'h1);
        check("drop_arrive_pc", if_pc, 32'h40);

        // Redirect and stall in the same cycle: redirect wins, target aligned.
        lat_min = 0;
        lat_max = 0;
        repeat (6) tick();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        sb_restart(32'h103);
        tick();
        redirect = 1'b0;
        check("redir_stall_valid", {31'b0, if_valid}, 32'h0);
        check("redir_stall_addr", imem_addr, 32'h100);
        check("redir_stall_req", {31'b0, imem_req}, 32'h1);
        tick();
        check("redir_load_pc", if_pc, 32'h100);
        stall = 1'b0;

        // Wrap-around from a RESET_PC near the top of the address space.
        rst_w = 1'b0;
        tick();
        check("wrap_pc0", pc_w, 32'hFFFF_FFF8);
        check("wrap_p4_0", p4_w, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc1", pc_w, 32'hFFFF_FFFC);
        check("wrap_p4_1", p4_w, 32'h0);
        tick();
        check("wrap_pc2", pc_w, 32'h0);
        check("wrap_valid", {31'b0, valid_w}, 32'h1);

        // Reset asserted while the hold buffer is occupied.
        repeat (3) tick();
        stall = 1'b1;
        tick();
        check("hold_entered", {31'b0, imem_req}, 32'h0);
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, if_valid}, 32'h0);
        check("async_rst_instr", if_instr, 32'h0);
        check("async_rst_pc", if_pc, 32'h0);
        check("async_rst_req", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb_restart(32'h0);
        #1;
        check("restart_addr", imem_addr, 32'h0);
        check("restart_req", {31'b0, imem_req}, 32'h1);
        tick();
        check("restart_pc", if_pc, 32'h0);

        // Randomized traffic.
        lat_min = 0;
        lat_max = 2;
        rand_start = n_consumed;
        for (int c = 0; c < 2000; c++) begin
            stall    = ($urandom_range(99, 0) < 30);
            redirect = ($urandom_range(99, 0) < 7);
            if (redirect) begin
                redirect_pc = $urandom;
                sb_restart(redirect_pc);
            end
            tick();
        end
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (10) tick();
        check("random_progress", {31'b0, (n_consumed - rand_start) > 100}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
